// File: rtl/buzz_seq.sv
// Buzzer pattern sequencer: gates a square-wave tone into ON/OFF bursts
// (slow, fast or continuous) with registered drive, gate, busy and done outputs.
module buzz_seq #(
  parameter int DIV_W  = 16,
  parameter int GATE_W = 24,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  tone_div,
  input  logic [GATE_W-1:0] on_len,
  input  logic [GATE_W-1:0] off_len,
  input  logic [CNT_W-1:0]  bursts,
  output logic              beep_r,
  output logic              beep,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_FAST = 2'b10;
  localparam logic [1:0] MODE_CONT = 2'b11;

  state_t              state_r, state_s;
  logic [1:0]          mode_r;
  logic [DIV_W-1:0]    div_r, tone_cnt_r, tone_cnt_s;
  logic [GATE_W-1:0]   on_r, off_r, gate_cnt_r, gate_cnt_s;
  logic [CNT_W-1:0]    bursts_r, burst_cnt_r, burst_cnt_s, burst_inc_s;
  logic                beep_r_s, done_s, latch_s;

  // Effective gate length: quarter length in fast mode, never below one cycle.
  function automatic logic [GATE_W-1:0] eff_gate(input logic [GATE_W-1:0] len,
                                                  input logic fast);
    logic [GATE_W-1:0] v;
    v = fast ? (len >> 2) : len;
    if (v == {GATE_W{1'b0}}) begin
      v = GATE_W'(1);
    end else begin
      v = v;
    end
    return v;
  endfunction

  // Next-state, counter and output-drive decode.
  always_comb begin
    state_s     = state_r;
    tone_cnt_s  = tone_cnt_r;
    gate_cnt_s  = gate_cnt_r;
    burst_cnt_s = burst_cnt_r;
    beep_r_s    = 1'b0;
    done_s      = 1'b0;
    latch_s     = 1'b0;
    burst_inc_s = (burst_cnt_r == {CNT_W{1'b1}}) ? burst_cnt_r : burst_cnt_r + CNT_W'(1);
    case (state_r)
      ST_IDLE: begin
        if (start && !stop && (mode != MODE_OFF)) begin
          latch_s     = 1'b1;
          state_s     = ST_ON;
          tone_cnt_s  = {DIV_W{1'b0}};
          gate_cnt_s  = {GATE_W{1'b0}};
          burst_cnt_s = {CNT_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ON: begin
        if (stop) begin
          state_s = ST_IDLE;
        end else begin
          if (tone_cnt_r == div_r - DIV_W'(1)) begin
            tone_cnt_s = {DIV_W{1'b0}};
            beep_r_s   = ~beep_r;
          end else begin
            tone_cnt_s = tone_cnt_r + DIV_W'(1);
            beep_r_s   = beep_r;
          end
          // Continuous mode never ends its ON phase on its own.
          if ((mode_r != MODE_CONT) && (gate_cnt_r == on_r - GATE_W'(1))) begin
            gate_cnt_s  = {GATE_W{1'b0}};
            tone_cnt_s  = {DIV_W{1'b0}};
            beep_r_s    = 1'b0;
            burst_cnt_s = burst_inc_s;
            if ((bursts_r != {CNT_W{1'b0}}) && (burst_inc_s == bursts_r)) begin
              state_s = ST_IDLE;
              done_s  = 1'b1;
            end else begin
              state_s = ST_OFF;
            end
          end else if (mode_r != MODE_CONT) begin
            gate_cnt_s = gate_cnt_r + GATE_W'(1);
          end else begin
            gate_cnt_s = gate_cnt_r;
          end
        end
      end
      ST_OFF: begin
        if (stop) begin
          state_s = ST_IDLE;
        end else if (gate_cnt_r == off_r - GATE_W'(1)) begin
          state_s    = ST_ON;
          gate_cnt_s = {GATE_W{1'b0}};
          tone_cnt_s = {DIV_W{1'b0}};
        end else begin
          gate_cnt_s = gate_cnt_r + GATE_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      tone_cnt_r  <= {DIV_W{1'b0}};
      gate_cnt_r  <= {GATE_W{1'b0}};
      burst_cnt_r <= {CNT_W{1'b0}};
      beep_r      <= 1'b0;
      beep        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_r     <= state_s;
      tone_cnt_r  <= tone_cnt_s;
      gate_cnt_r  <= gate_cnt_s;
      burst_cnt_r <= burst_cnt_s;
      beep_r      <= beep_r_s;
      beep        <= (state_s == ST_ON);
      busy        <= (state_s != ST_IDLE);
      done        <= done_s;
    end
  end

  // Pattern parameters, captured only on an accepted start with zero clamps applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r   <= MODE_OFF;
      div_r    <= {DIV_W{1'b0}};
      on_r     <= {GATE_W{1'b0}};
      off_r    <= {GATE_W{1'b0}};
      bursts_r <= {CNT_W{1'b0}};
    end else if (latch_s) begin
      mode_r   <= mode;
      div_r    <= (tone_div == {DIV_W{1'b0}}) ? DIV_W'(1) : tone_div;
      on_r     <= eff_gate(on_len, mode == MODE_FAST);
      off_r    <= eff_gate(off_len, mode == MODE_FAST);
      bursts_r <= bursts;
    end else begin
      mode_r   <= mode_r;
      div_r    <= div_r;
      on_r     <= on_r;
      off_r    <= off_r;
      bursts_r <= bursts_r;
    end
  end

endmodule

// File: doc/buzz_seq.md
BUZZ_SEQ -- requirements
Module: buzz_seq

Interface
REQ-001 Parameter DIV_W, default 16: width of the tone half-period divider.
REQ-002 Parameter GATE_W, default 24: width of the on/off gate-length counters.
REQ-003 Parameter CNT_W, default 8: width of the burst counter.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1: reset, asynchronous, active-high.
REQ-006 Port start  input  1: one-cycle request to begin a pattern.
REQ-007 Port stop  input  1: abort the pattern; level-sampled each cycle.
REQ-008 Port mode  input  2: 00 off, 01 slow, 10 fast, 11 continuous.
REQ-009 Port tone_div  input  DIV_W: tone half-period in clk cycles.
REQ-010 Port on_len  input  GATE_W: ON-phase length in clk cycles.
REQ-011 Port off_len  input  GATE_W: OFF-phase length in clk cycles.
REQ-012 Port bursts  input  CNT_W: number of ON phases; 0 means endless.
REQ-013 Port beep_r  output  1: square-wave drive to the buzzer.
REQ-014 Port beep  output  1: tone gate; high exactly while in ON.
REQ-015 Port busy  output  1: high in any state other than IDLE.
REQ-016 Port done  output  1: one-cycle pulse on normal pattern completion.

Function
REQ-017 FSM states are IDLE, ON and OFF; all outputs are registered.
REQ-018 In IDLE with start=1, stop=0 and mode!=00, the block latches mode, tone_div, on_len, off_len and bursts, and enters ON on the next edge.
REQ-019 start is ignored when mode=00, when stop=1 in the same cycle, or while busy=1.
REQ-020 Latched zero values of tone_div, on_len and off_len are treated as 1.
REQ-021 Effective gate lengths: slow uses on_len/off_len as latched; fast uses on_len>>2 and off_len>>2, each floored at 1.
REQ-022 Continuous mode stays in ON until stop; bursts and off_len are ignored; done never pulses.
REQ-023 On ON entry, the tone counter clears and beep_r=0.
REQ-024 In ON, the tone counter counts 0..tone_div-1; at tone_div-1, beep_r toggles and the counter wraps to 0.
REQ-025 beep_r is forced to 0 in IDLE and OFF; beep=1 in ON and 0 otherwise.
REQ-026 ON lasts exactly the effective on-length in cycles; at its end, the burst counter increments by 1.
REQ-027 At the end of ON, if bursts!=0 and the incremented count equals bursts: go to IDLE, assert done for 1 cycle, and do not enter a trailing OFF.
REQ-028 Otherwise ON goes to OFF; OFF lasts the effective off-length in cycles, then returns to ON.
REQ-029 In endless mode (bursts=0), the burst counter saturates at all-ones and does not wrap.
REQ-030 stop=1 in ON or OFF forces IDLE on the next edge; done stays 0; beep and beep_r drop to 0 that edge.
REQ-031 Input changes while busy have no effect until the next accepted start.
REQ-032 Latency: beep rises 1 cycle after an accepted start; beep_r first rises tone_div cycles after beep rises.

Reset
REQ-033 rst=1 asynchronously forces IDLE, clears all counters and latched parameters, and drives beep_r, beep, busy and done to 0.
REQ-034 rst asserted mid-pattern aborts immediately with no done pulse.
REQ-035 After rst deasserts, the first rising clk edge may accept a start.

Verification
REQ-036 Slow tone: mode=01, tone_div=2, on_len=8, off_len=4, bursts=2, start pulse -> beep high 8 cycles, low 4, high 8; beep_r toggles every 2 cycles (period 4) in ON; done pulses 1 cycle after the second ON; busy low the following cycle.
REQ-037 Fast scaling: mode=10, on_len=8, off_len=2, bursts=1 -> ON lasts 2 cycles, no OFF phase, done pulses once.
REQ-038 Zero clamps and continuous mode: mode=11, tone_div=0, on_len=0 -> beep_r toggles every cycle; beep stays high for 100 cycles until stop=1, then beep=0 and busy=0 on the next edge; done=0 throughout.
REQ-039 Ignored starts: mode=00 start -> busy stays 0; start during ON of a bursts=3 pattern -> pattern unchanged, exactly 3 ON phases.
REQ-040 Async reset: rst asserted between clock edges during OFF -> busy, beep and beep_r go to 0 before the next edge; no done pulse.
REQ-041 Simultaneous start and stop in IDLE -> remains IDLE, busy=0.
